// File: rtl/uart_fifo_mmio.sv
// UART with TX/RX FIFOs, programmable divisor, ms counter and level IRQ on the RV32I peripheral bus.
// Register reads are combinational; a push to a full TX FIFO is dropped; RX overrun sets a sticky flag.

module uart_fifo_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic [7:0]               push_dat,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head    = mem[rp];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wp] <= push_dat;
  end

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

module uart_fifo_mmio #(
  parameter int DEFAULT_DIV = 48,
  parameter int TX_DEPTH    = 16,
  parameter int RX_DEPTH    = 16,
  parameter int MS_TICKS    = 48000
) (
  input  logic        clk_i,
  input  logic        rstn,
  input  logic        m_sel,
  input  logic [3:0]  m_addr,
  input  logic [31:0] m_data_i,
  output logic [31:0] m_data_o,
  input  logic        m_rd,
  input  logic        m_wr,
  input  logic        RXD,
  output logic        TXD,
  output logic        irq_o
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        unused_rd;
  logic        hit, fire, we_q;
  logic [3:0]  addr_q;
  logic        wr_data, wr_stat, wr_ms, wr_div, wr_ctrl, flush, rx_pop;
  logic [15:0] div;
  logic        loopback, rx_irq_en, tx_irq_en;
  logic        overflow, frame_err;
  logic [31:0] ms_cnt, presc;

  logic [7:0]  tx_head, rx_head;
  logic [$clog2(TX_DEPTH):0] tx_count;
  logic [$clog2(RX_DEPTH):0] rx_count;
  logic        tx_full, tx_empty, rx_full, rx_empty;

  logic        tx_busy, txd_r, tx_load, tx_frame_end;
  logic [8:0]  tx_shift;
  logic [3:0]  tx_bits;
  logic [15:0] tx_cnt, tx_div;

  logic        sync1, sync2, rx_in;
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  rx_bits, rx_bits_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_armed, rx_armed_n, rx_push, rx_ferr;
  logic        tx_idle, rx_avail;
  logic [31:0] status;

  assign unused_rd = m_rd;

  // Side effects fire only on the first cycle of a held strobe to the same address.
  assign hit     = m_sel & m_wr;
  assign fire    = hit & ~(we_q & (addr_q == m_addr));
  assign wr_data = fire & (m_addr == 4'd0);
  assign wr_stat = fire & (m_addr == 4'd1);
  assign wr_ms   = fire & (m_addr == 4'd2);
  assign wr_div  = fire & (m_addr == 4'd3);
  assign wr_ctrl = fire & (m_addr == 4'd4);
  assign flush   = wr_ctrl & m_data_i[1];
  assign rx_pop  = wr_stat & m_data_i[0];

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      we_q   <= 1'b0;
      addr_q <= '0;
    end else begin
      we_q   <= hit;
      addr_q <= m_addr;
    end
  end

  uart_fifo_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(clk_i), .rstn(rstn), .flush(flush), .push(wr_data), .push_dat(m_data_i[7:0]),
    .pop(tx_load), .head(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  uart_fifo_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(clk_i), .rstn(rstn), .flush(flush), .push(rx_push), .push_dat(rx_shift_n),
    .pop(rx_pop), .head(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      div       <= 16'(DEFAULT_DIV);
      loopback  <= 1'b0;
      rx_irq_en <= 1'b0;
      tx_irq_en <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
      ms_cnt    <= '0;
      presc     <= '0;
      irq_o     <= 1'b0;
    end else begin
      if (wr_div) div <= (m_data_i[15:0] < 16'd2) ? 16'd2 : m_data_i[15:0];
      if (wr_ctrl) begin
        loopback  <= m_data_i[0];
        rx_irq_en <= m_data_i[2];
        tx_irq_en <= m_data_i[3];
      end
      if (rx_push & rx_full & ~flush) overflow <= 1'b1;
      else if (wr_stat & m_data_i[4]) overflow <= 1'b0;
      if (rx_ferr) frame_err <= 1'b1;
      else if (wr_stat & m_data_i[5]) frame_err <= 1'b0;
      if (presc == 32'(MS_TICKS - 1)) begin
        presc  <= '0;
        ms_cnt <= ms_cnt + 32'd1;
      end else begin
        presc <= presc + 32'd1;
      end
      if (wr_ms) ms_cnt <= m_data_i;
      irq_o <= (rx_irq_en & rx_avail) | (tx_irq_en & tx_idle);
    end
  end

  // TX shifter: the frame end and the next start bit share an edge so frames run back-to-back.
  assign tx_frame_end = tx_busy & (tx_cnt == 16'd0) & (tx_bits == 4'd0);
  assign tx_load      = (~tx_busy | tx_frame_end) & ~tx_empty & ~flush;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      tx_busy  <= 1'b0;
      txd_r    <= 1'b1;
      tx_shift <= '0;
      tx_bits  <= '0;
      tx_cnt   <= '0;
      tx_div   <= '0;
    end else if (tx_load) begin
      tx_busy  <= 1'b1;
      txd_r    <= 1'b0;
      tx_shift <= {1'b1, tx_head};
      tx_bits  <= 4'd9;
      tx_div   <= div;
      tx_cnt   <= div - 16'd1;
    end else if (tx_busy) begin
      if (tx_cnt != 16'd0) begin
        tx_cnt <= tx_cnt - 16'd1;
      end else if (tx_bits == 4'd0) begin
        tx_busy <= 1'b0;
      end else begin
        txd_r    <= tx_shift[0];
        tx_shift <= {1'b0, tx_shift[8:1]};
        tx_bits  <= tx_bits - 4'd1;
        tx_cnt   <= tx_div - 16'd1;
      end
    end
  end

  assign TXD   = loopback ? 1'b1 : txd_r;
  assign rx_in = loopback ? txd_r : sync2;

  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_div   <= 16'(DEFAULT_DIV);
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_armed <= 1'b1;
    end else begin
      sync1    <= RXD;
      sync2    <= sync1;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_div   <= rx_div_n;
      rx_bits  <= rx_bits_n;
      rx_shift <= rx_shift_n;
      rx_armed <= rx_armed_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_div_n   = rx_div;
    rx_bits_n  = rx_bits;
    rx_shift_n = rx_shift;
    rx_armed_n = rx_armed;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_in) begin
          rx_armed_n = 1'b1;
        end else if (rx_armed) begin
          rx_state_n = RX_START;
          rx_div_n   = div;
        end
      end
      RX_START: begin
        if (rx_in) begin
          rx_state_n = RX_IDLE;
        end else if (rx_cnt == {1'b0, rx_div[15:1]} - 16'd1) begin
          rx_state_n = RX_DATA;
          rx_cnt_n   = '0;
          rx_bits_n  = '0;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == rx_div - 16'd1) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_in, rx_shift[7:1]};
          rx_bits_n  = rx_bits + 3'd1;
          if (rx_bits == 3'd7) rx_state_n = RX_STOP;
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == rx_div - 16'd1) begin
          rx_state_n = RX_IDLE;
          rx_cnt_n   = '0;
          if (rx_in) begin
            rx_push = 1'b1;
          end else begin
            rx_ferr    = 1'b1;
            rx_armed_n = 1'b0;
          end
        end else begin
          rx_cnt_n = rx_cnt + 16'd1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  assign tx_idle  = tx_empty & ~tx_busy;
  assign rx_avail = ~rx_empty;
  assign status   = {8'd0, 8'(tx_count), 8'(rx_count), 2'b00, frame_err, overflow,
                     rx_full, tx_full, rx_avail, tx_idle};

  always_comb begin
    m_data_o = '0;
    if (m_sel) begin
      case (m_addr)
        4'd0:    m_data_o = {24'd0, rx_head};
        4'd1:    m_data_o = status;
        4'd2:    m_data_o = ms_cnt;
        4'd3:    m_data_o = {16'd0, div};
        4'd4:    m_data_o = {28'd0, tx_irq_en, rx_irq_en, 1'b0, loopback};
        default: m_data_o = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_mmio.sv
// Directed bench for uart_fifo_mmio: reset, ms counter, TX timing, loopback, overflow, framing, glitch, IRQ.
module tb_uart_fifo_mmio;
  logic        clk_i = 1'b0;
  logic        rstn = 1'b0;
  logic        m_sel = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [31:0] m_data_i = '0;
  logic [31:0] m_data_o;
  logic        m_rd = 1'b0;
  logic        m_wr = 1'b0;
  logic        RXD = 1'b1;
  logic        TXD;
  logic        irq_o;

  int n_vec = 0;
  int n_err = 0;

  localparam int BIT = 48;

  uart_fifo_mmio #(.DEFAULT_DIV(48), .TX_DEPTH(16), .RX_DEPTH(16), .MS_TICKS(48)) dut (
    .clk_i(clk_i), .rstn(rstn), .m_sel(m_sel), .m_addr(m_addr), .m_data_i(m_data_i),
    .m_data_o(m_data_o), .m_rd(m_rd), .m_wr(m_wr), .RXD(RXD), .TXD(TXD), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    m_sel  = 1'b1;
    m_addr = a;
    #1 d = m_data_o;
    m_sel  = 1'b0;
  endtask

  // One-cycle strobe followed by one idle cycle so back-to-back writes are distinct.
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    m_sel = 1'b1; m_wr = 1'b1; m_addr = a; m_data_i = d;
    @(negedge clk_i);
    m_sel = 1'b0; m_wr = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    RXD = 1'b0;
    repeat (BIT) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      repeat (BIT) @(negedge clk_i);
    end
    RXD = stop;
    repeat (BIT) @(negedge clk_i);
    RXD = 1'b1;
    repeat (2 * BIT) @(negedge clk_i);
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  pat;
    logic        txd_low_seen, avail_seen, irq_at0, irq_at1;

    // Reset state
    repeat (3) @(negedge clk_i);
    rstn = 1'b1;
    check_eq("rst_txd", 32'(TXD), 32'd1);
    check_eq("rst_irq", 32'(irq_o), 32'd0);
    bus_read(4'd1, d); check_eq("rst_status", d, 32'h0000_0001);
    bus_read(4'd3, d); check_eq("rst_div", d, 32'd48);
    bus_read(4'd4, d); check_eq("rst_ctrl", d, 32'd0);

    // ms counter: 479 edges -> 9, 480 edges -> 10
    repeat (479) @(negedge clk_i);
    bus_read(4'd2, d); check_eq("ms_479", d, 32'd9);
    @(negedge clk_i);
    bus_read(4'd2, d); check_eq("ms_480", d, 32'd10);
    bus_write(4'd2, 32'h1234_0000);
    bus_read(4'd2, d); check_eq("ms_load", d, 32'h1234_0000);

    // Divisor floor
    bus_write(4'd3, 32'd1);
    bus_read(4'd3, d); check_eq("div_floor", d, 32'd2);
    bus_write(4'd3, 32'd48);
    bus_read(4'd3, d); check_eq("div_48", d, 32'd48);
    bus_read(4'd9, d); check_eq("unmapped_rd", d, 32'd0);

    // TX frame 0x55 with exact bit timing
    m_sel = 1'b1; m_wr = 1'b1; m_addr = 4'd0; m_data_i = 32'h55;
    @(negedge clk_i);
    m_sel = 1'b0; m_wr = 1'b0;
    check_eq("tx_n1_idle", 32'(TXD), 32'd1);
    @(negedge clk_i);
    check_eq("tx_start_first", 32'(TXD), 32'd0);
    repeat (47) @(negedge clk_i);
    check_eq("tx_start_last", 32'(TXD), 32'd0);
    @(negedge clk_i);
    check_eq("tx_bit0_first", 32'(TXD), 32'd1);
    repeat (24) @(negedge clk_i);
    pat = 8'h55;
    for (int i = 1; i < 8; i++) begin
      repeat (BIT) @(negedge clk_i);
      check_eq($sformatf("tx_bit%0d", i), 32'(TXD), 32'(pat[i]));
    end
    repeat (BIT) @(negedge clk_i);
    check_eq("tx_stop", 32'(TXD), 32'd1);
    repeat (23) @(negedge clk_i);
    bus_read(4'd1, d); check_eq("tx_idle_n481", 32'(d[0]), 32'd0);
    @(negedge clk_i);
    bus_read(4'd1, d); check_eq("tx_idle_n482", 32'(d[0]), 32'd1);

    // Loopback with rx irq: A5 then 3C written with a 5-cycle held strobe
    bus_write(4'd4, 32'h5);
    bus_write(4'd0, 32'hA5);
    m_sel = 1'b1; m_wr = 1'b1; m_addr = 4'd0; m_data_i = 32'h3C;
    repeat (5) @(negedge clk_i);
    m_sel = 1'b0; m_wr = 1'b0;
    @(negedge clk_i);
    bus_read(4'd1, d); check_eq("hold_tx_count", 32'(d[23:16]), 32'd1);
    txd_low_seen = 1'b0; avail_seen = 1'b0; irq_at0 = 1'b1; irq_at1 = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      bus_read(4'd1, d);
      if (d[15:8] == 8'd2) break;
      if (!avail_seen && d[1]) begin
        avail_seen = 1'b1;
        irq_at0 = irq_o;
        @(negedge clk_i);
        irq_at1 = irq_o;
      end
      if (TXD == 1'b0) txd_low_seen = 1'b1;
      @(negedge clk_i);
    end
    check_eq("lb_rx_count", 32'(d[15:8]), 32'd2);
    check_eq("lb_txd_high", 32'(txd_low_seen), 32'd0);
    check_eq("irq_same_cycle", 32'(irq_at0), 32'd0);
    check_eq("irq_next_cycle", 32'(irq_at1), 32'd1);
    bus_read(4'd0, d); check_eq("lb_head0", d, 32'hA5);
    bus_write(4'd1, 32'h1);
    bus_read(4'd0, d); check_eq("lb_head1", d, 32'h3C);
    bus_write(4'd1, 32'h1);
    bus_read(4'd1, d); check_eq("lb_drained", 32'(d[15:8]), 32'd0);

    // Overflow: 17 bytes into a 16-deep RX FIFO
    for (int i = 1; i <= 17; i++) bus_write(4'd0, 32'(i));
    for (int c = 0; c < 10000; c++) begin
      bus_read(4'd1, d);
      if (d[0]) break;
      @(negedge clk_i);
    end
    repeat (4) @(negedge clk_i);
    bus_read(4'd1, d);
    check_eq("ovf_rx_count", 32'(d[15:8]), 32'd16);
    check_eq("ovf_flag", 32'(d[4]), 32'd1);
    check_eq("ovf_rx_full", 32'(d[3]), 32'd1);
    bus_read(4'd0, d); check_eq("ovf_head", d, 32'd1);
    bus_write(4'd1, 32'h10);
    bus_read(4'd1, d); check_eq("ovf_clear", 32'(d[4]), 32'd0);
    bus_write(4'd4, 32'h3);
    bus_read(4'd1, d); check_eq("flush_rx_count", 32'(d[15:8]), 32'd0);
    bus_read(4'd4, d); check_eq("flush_selfclr", d, 32'h1);

    // External RXD: bad stop bit, then a valid frame
    bus_write(4'd4, 32'h0);
    send_rx(8'h81, 1'b0);
    bus_read(4'd1, d);
    check_eq("ferr_flag", 32'(d[5]), 32'd1);
    check_eq("ferr_rx_count", 32'(d[15:8]), 32'd0);
    send_rx(8'h42, 1'b1);
    bus_read(4'd1, d); check_eq("rx_ok_count", 32'(d[15:8]), 32'd1);
    bus_read(4'd0, d); check_eq("rx_ok_data", d, 32'h42);
    bus_write(4'd1, 32'h21);
    bus_read(4'd1, d); check_eq("ferr_clear", d & 32'h0000_FF30, 32'd0);

    // 10-cycle low glitch is rejected
    RXD = 1'b0;
    repeat (10) @(negedge clk_i);
    RXD = 1'b1;
    repeat (12 * BIT) @(negedge clk_i);
    bus_read(4'd1, d); check_eq("glitch_status", d & 32'h0000_FF30, 32'd0);

    // tx irq: idle transmitter raises irq one cycle after enable
    bus_write(4'd4, 32'h8);
    check_eq("tx_irq", 32'(irq_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_fifo_mmio.md
Name: uart_fifo_mmio

Overview:
Parametrised successor to the SoC's fixed-rate UART and millisecond timer peripheral. It adds TX and RX FIFOs, a runtime-programmable baud divisor, framing and overflow error detection, internal loopback, FIFO flush and a level interrupt. It attaches to the RV32I memory bus with the same select, address, read and write strobe interface as the other peripherals, decoded by the SoC top.

Parameters:
DEFAULT_DIV, 48, reset value of the baud divisor, in clk_i cycles per bit (1 Mb/s at 48 MHz)
TX_DEPTH, 16, TX FIFO entries; power of 2, range 2..128
RX_DEPTH, 16, RX FIFO entries; power of 2, range 2..128
MS_TICKS, 48000, clk_i cycles per millisecond-counter increment

Ports:
clk_i  in  1  system clock
rstn  in  1  reset; asynchronous, active-low
m_sel  in  1  peripheral selected
m_addr  in  4  word address (cpu_ad[5:2])
m_data_i  in  32  write data
m_data_o  out  32  read data, combinational from m_sel and m_addr
m_rd  in  1  read strobe
m_wr  in  1  write strobe
RXD  in  1  serial input, asynchronous
TXD  out  1  serial output
irq_o  out  1  registered interrupt request, level-sensitive

Behaviour:
- Reset values: TXD=1, irq_o=0, both FIFOs empty, sticky flags 0, divisor=DEFAULT_DIV, ctrl=0, ms counter=0, prescaler=0.
- Register map (m_addr):
  - 0 DATA: write pushes m_data_i[7:0] to TX FIFO. Read returns {24'b0, RX head} and does not pop.
  - 1 STATUS: read returns the fields below.
    - [0] tx_idle: TX FIFO empty and shifter idle
    - [1] rx_avail
    - [2] tx_full
    - [3] rx_full
    - [4] overflow (sticky)
    - [5] frame_err (sticky)
    - [15:8] rx_count
    - [23:16] tx_count
    - others 0
  - 1 STATUS: write bit0=1 pops RX (ignored if empty); bit4=1 clears overflow; bit5=1 clears frame_err.
  - 2 MS: read returns ms counter; write loads it.
  - 3 DIV: [15:0] read/write; written values below 2 are stored as 2.
  - 4 CTRL:
    - [0] loopback
    - [1] flush: write-only, self-clearing, empties both FIFOs; an in-flight TX frame completes
    - [2] rx_irq_en
    - [3] tx_irq_en
  - Unmapped addresses read 0; writes to them are ignored.
- Strobe qualification:
  - All side effects (push, pop, clear, load, flush) fire once, on the first cycle of a contiguous assertion of m_sel & m_wr & matching address. A held strobe does not repeat the action.
  - A push to a full TX FIFO is dropped silently.
- TX timing:
  - If the shifter is idle and a push occurs at cycle N, TXD=0 (start bit) from cycle N+2.
  - Frame: start, 8 data bits LSB first, 1 stop bit; each bit lasts DIV cycles, so a frame is 10*DIV cycles.
  - The next byte's start bit follows the stop bit back-to-back.
  - DIV is latched at frame start; a change mid-frame takes effect on the next frame.
- RX input path: RXD passes through a 2-flop synchroniser. With loopback=1, the RX input is the internal TX serial stream and TXD is held at 1.
- RX state machine (IDLE, START, DATA, STOP):
  - IDLE -> START when the input goes low.
  - START: if the input stays low for DIV/2 consecutive cycles, go to DATA; if it returns high earlier, go back to IDLE (glitch rejected).
  - DATA: sample every DIV cycles; 8 samples, LSB first.
  - STOP: sample once more. If the stop sample is 1, push the byte. If it is 0, set frame_err, discard the byte, and wait in IDLE until the input is high before re-arming.
  - A push into a full RX FIFO sets overflow and drops the new byte; the existing contents are preserved.
- Simultaneous events: a push and an RX pop in the same cycle are independent. A FIFO push and pop in the same cycle keeps the count unchanged. A flush wins over a concurrent push or pop.
- ms counter: the prescaler counts 0..MS_TICKS-1; on wrap the counter increments (a period of exactly MS_TICKS cycles), wrapping 32-bit.
- irq_o is registered (1-cycle latency): irq_o <= (rx_irq_en & rx_avail) | (tx_irq_en & tx_idle).
- An async reset mid-frame forces TXD=1 immediately and abandons the frame.

Test Plan:
- DIV=48, write 0x55 to DATA at cycle N -> TXD=0 at N+2; bits 1,0,1,0,1,0,1,0 at 48 cycles each; stop=1; tx_idle=1 at N+2+480.
- Loopback=1, push 0xA5, 0x3C -> rx_count=2, DATA reads 0xA5; pop -> DATA reads 0x3C; TXD stays 1 throughout.
- Loopback, push 17 bytes with RX_DEPTH=16 and no pops -> rx_count=16, overflow=1, head is the first byte; write STATUS 0x10 -> overflow=0.
- RXD frame 0x81 with stop bit driven 0 -> frame_err=1, rx_count=0; a following valid frame 0x42 -> rx_count=1, data 0x42.
- Hold m_wr for 5 cycles on DATA -> tx_count increments by exactly 1; RXD low pulse of 10 cycles -> no byte received, no error flag set.
- MS_TICKS=48: after 480 cycles MS=10; write DIV=1 -> DIV reads 2; rx_irq_en=1 with a byte received -> irq_o=1 one cycle after rx_avail.
